sync_dr_src: RTL

- Clocked-to-dual-rail injector that sits directly upstream of a mem_reg stage.
- Accepts single-rail words on a clocked valid/ready interface and encodes each word as a dual-rail token (FP four-phase or TP two-phase).
- Drives the token onto the async pipeline input and retires it against the downstream stage's completion/ack signal, which is asynchronous to clk and is therefore synchronised.

---
 rtl/dr_pkg.sv | 29 ++
 rtl/ack_sync.sv | 31 +++
 rtl/sync_dr_src.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dr_pkg.sv
// Shared dual-rail definitions for the clocked-to-dual-rail injector and
// its consumer-side counterpart.
//   RAIL_NUM       rails per data bit (rail1 = logic 1, rail0 = logic 0)
//   ENC_FP/ENC_TP  encoding selector strings (four-phase / two-phase)
//   fp_state_t     four-phase sequencer states
//   tp_state_t     two-phase sequencer states
//   dr_enc()       single-rail bit -> one-hot rail pair
package dr_pkg;

  localparam int    RAIL_NUM = 2;
  localparam string ENC_FP   = "FP";
  localparam string ENC_TP   = "TP";

  typedef enum logic [1:0] {
    FP_IDLE,
    FP_DATA,
    FP_NULL
  } fp_state_t;

  typedef enum logic {
    TP_IDLE,
    TP_WAIT
  } tp_state_t;

  function automatic logic [RAIL_NUM-1:0] dr_enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Flop-chain synchroniser for an asynchronous completion/ack level.
//   clk     sampling clock
//   rst_n   asynchronous active-low reset, chain clears to 0
//   d       asynchronous input
//   q       synchronised level (after STAGES flops)
//   q_next  value q takes on the next edge; lets a caller register
//           decisions that must line up exactly with q
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_next
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q      = chain[STAGES-1];
  assign q_next = chain[STAGES-2];

endmodule

// File: rtl/sync_dr_src.sv
// Clocked-to-dual-rail injector feeding a mem_reg stage.
// Takes single-rail words on a valid/ready interface, encodes each as a
// dual-rail token (four-phase return-to-null or two-phase transition) and
// retires it against the synchronised downstream ack.
//   clk       block clock
//   rst_n     asynchronous active-low reset
//   in_valid  word available
//   in_ready  block accepts a word this cycle (registered)
//   in_data   single-rail word
//   ack_i     downstream completion, asynchronous to clk
//   out       dual-rail token, out[b] = {rail1, rail0} (registered)
// Build option: SYNC_DR_SRC_SKID_EN adds a one-entry holding register so a
// word can be accepted while a token is in flight.
//
// state   | meaning
// FP_IDLE | rails at NULL, ready for a word once ack has returned low
// FP_DATA | data token on the rails, waiting for ack high
// FP_NULL | NULL spacer on the rails, waiting for ack low
// TP_IDLE | rails hold last token, ready for a word
// TP_WAIT | token launched, waiting for ack to change level
module sync_dr_src
  import dr_pkg::*;
#(
  parameter string ENC         = "FP",
  parameter int    WIDTH       = 8,
  parameter int    SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             ack_i,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   out
);

  localparam bit IS_FP = (ENC == ENC_FP);
  localparam bit IS_TP = (ENC == ENC_TP);

  logic ack_s;
  logic ack_s_nxt;
  logic fire;
  logic launch;
  logic can_launch;
  logic idle_nxt;
  logic [WIDTH-1:0]               launch_data;
  logic [WIDTH-1:0][RAIL_NUM-1:0] enc_word;

  ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ack_i),
    .q      (ack_s),
    .q_next (ack_s_nxt)
  );

  assign fire = in_valid & in_ready;

`ifdef SYNC_DR_SRC_SKID_EN
  logic             skid_full;
  logic             skid_full_nxt;
  logic             store;
  logic [WIDTH-1:0] skid_data;

  // The held word always goes first; a direct launch only happens when the
  // slot is empty, which keeps ordering strictly FIFO.
  assign launch        = can_launch & (skid_full | fire);
  assign launch_data   = skid_full ? skid_data : in_data;
  assign store         = fire & ~(launch & ~skid_full);
  assign skid_full_nxt = (skid_full & ~launch) | store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else begin
      skid_full <= skid_full_nxt;
      if (store) begin
        skid_data <= in_data;
      end
    end
  end
`else
  assign launch      = fire & can_launch;
  assign launch_data = in_data;
`endif

  always_comb begin
    enc_word = '0;
    for (int b = 0; b < WIDTH; b++) begin
      enc_word[b] = dr_enc(launch_data[b]);
    end
  end

  // in_ready is registered from next-cycle state; using the synchroniser's
  // next value makes it track !ack_s in FP_IDLE cycle-exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
`ifdef SYNC_DR_SRC_SKID_EN
      in_ready <= ~skid_full_nxt;
`else
      in_ready <= idle_nxt & ~(IS_FP & ack_s_nxt);
`endif
    end
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_dr_src: SYNC_STAGES must be at least 2");
  end

  if (IS_FP) begin : g_fp
    fp_state_t state;

    assign can_launch = (state == FP_IDLE) & ~ack_s;
    assign idle_nxt   = ((state == FP_IDLE) & ~launch) |
                        ((state == FP_NULL) & ~ack_s);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= FP_IDLE;
        out   <= '0;
      end else begin
        case (state)
          FP_IDLE: begin
            if (launch) begin
              out   <= enc_word;
              state <= FP_DATA;
            end
          end
          FP_DATA: begin
            if (ack_s) begin
              out   <= '0;
              state <= FP_NULL;
            end
          end
          FP_NULL: begin
            if (!ack_s) begin
              state <= FP_IDLE;
            end
          end
          default: begin
            out   <= '0;
            state <= FP_IDLE;
          end
        endcase
      end
    end
  end else if (IS_TP) begin : g_tp
    tp_state_t state;
    logic      ack_h;

    assign can_launch = (state == TP_IDLE);
    assign idle_nxt   = ((state == TP_IDLE) & ~launch) |
                        ((state == TP_WAIT) & (ack_s != ack_h));

    // Rails are level-holding: a token flips exactly one rail per bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= TP_IDLE;
        ack_h <= 1'b0;
        out   <= '0;
      end else begin
        case (state)
          TP_IDLE: begin
            if (launch) begin
              out   <= out ^ enc_word;
              state <= TP_WAIT;
            end
          end
          TP_WAIT: begin
            if (ack_s != ack_h) begin
              ack_h <= ack_s;
              state <= TP_IDLE;
            end
          end
          default: begin
            state <= TP_IDLE;
          end
        endcase
      end
    end
  end else begin : g_bad_enc
    $error("sync_dr_src: ENC must be FP or TP");
  end

endmodule
